// File: rtl/somador_pkg.sv
// Shared definitions for the serial nibble-adder controller: FSM states,
// nibble width and the index-width helper.
package somador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOMA = 2'd1,
        FIM  = 2'd2
    } state_t;

    localparam int NIBBLE = 4;

    // Width of the nibble index for a given operand length; never below 1 bit.
    function automatic int idx_width(input int words);
        if (words <= 1) begin
            return 1;
        end
        return $clog2(words);
    endfunction

endpackage

// File: rtl/somador_4_bits.sv
// The lab's 4-bit ripple-carry adder, exposed bit by bit as on the bench board.
module somador_4_bits (
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    input  logic cin,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic cout
);

    logic c1;
    logic c2;
    logic c3;

    assign s0   = a0 ^ b0 ^ cin;
    assign c1   = (a0 & b0) | (a0 & cin) | (b0 & cin);
    assign s1   = a1 ^ b1 ^ c1;
    assign c2   = (a1 & b1) | (a1 & c1) | (b1 & c1);
    assign s2   = a2 ^ b2 ^ c2;
    assign c3   = (a2 & b2) | (a2 & c2) | (b2 & c2);
    assign s3   = a3 ^ b3 ^ c3;
    assign cout = (a3 & b3) | (a3 & c3) | (b3 & c3);

endmodule

// File: rtl/controlador_soma_serial.sv
// Adds two 4*WORDS-bit operands nibble by nibble through one somador_4_bits.
// Optional subtraction is built when SOMADOR_SUB_EN is defined.
module controlador_soma_serial
    import somador_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*WORDS-1:0]    a,
    input  logic [4*WORDS-1:0]    b,
`ifdef SOMADOR_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [4*WORDS-1:0]    soma,
    output logic                  cout,
    output state_t                dbg_state
);

    localparam int W  = NIBBLE * WORDS;
    localparam int IW = idx_width(WORDS);

    // Handshake: start is sampled only in IDLE; busy stays high for the WORDS
    // SOMA cycles; done pulses for one cycle when soma/cout take the new result.
    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    shadow;
    logic [W-1:0]    shadow_next;
    logic            carry;
    logic            carry_init;
    logic [IW-1:0]   idx;
    logic            last;
    logic [3:0]      op_a;
    logic [3:0]      op_b;
    logic [3:0]      add_sum;
    logic            add_cout;

`ifdef SOMADOR_SUB_EN
    logic            sub_reg;
    assign carry_init = sub;
    assign op_b       = sub_reg ? ~b_reg[idx*NIBBLE +: NIBBLE] : b_reg[idx*NIBBLE +: NIBBLE];
`else
    assign carry_init = 1'b0;
    assign op_b       = b_reg[idx*NIBBLE +: NIBBLE];
`endif

    assign op_a      = a_reg[idx*NIBBLE +: NIBBLE];
    assign last      = (idx == IW'(WORDS - 1));
    assign dbg_state = state;

    somador_4_bits u_somador (
        .a0   (op_a[0]),
        .a1   (op_a[1]),
        .a2   (op_a[2]),
        .a3   (op_a[3]),
        .b0   (op_b[0]),
        .b1   (op_b[1]),
        .b2   (op_b[2]),
        .b3   (op_b[3]),
        .cin  (carry),
        .s0   (add_sum[0]),
        .s1   (add_sum[1]),
        .s2   (add_sum[2]),
        .s3   (add_sum[3]),
        .cout (add_cout)
    );

    always_comb begin
        shadow_next = shadow;
        shadow_next[idx*NIBBLE +: NIBBLE] = add_sum;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SOMA;
            SOMA:    if (last)  state_next = FIM;
            FIM:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            shadow <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            soma   <= '0;
            cout   <= 1'b0;
`ifdef SOMADOR_SUB_EN
            sub_reg <= 1'b0;
`endif
        end else begin
            state <= state_next;
            busy  <= (state_next == SOMA);
            done  <= (state_next == FIM);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= carry_init;
                        idx   <= '0;
`ifdef SOMADOR_SUB_EN
                        sub_reg <= sub;
`endif
                    end
                end
                SOMA: begin
                    shadow <= shadow_next;
                    carry  <= add_cout;
                    if (last) begin
                        // Whole result published on one edge; shadow keeps partials hidden.
                        soma <= shadow_next;
                        cout <= add_cout;
                        idx  <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
